// File: rtl/text_glyph_pipe_if.sv
// Beat, glyph-ROM and pixel signals of the text glyph pipeline.
// master = beat source / ROM / pixel sink side, slave = the glyph pipeline.
interface text_glyph_pipe_if #(
   parameter int unsigned GLYPH_W  = 7,
   parameter int unsigned ROW_BITS = 3
);
   logic                  in_valid;
   logic                  in_cell_start;
   logic [7:0]            char_code;
   logic [ROW_BITS-1:0]   row;
   logic                  alt_charset;
   logic                  col80;
   logic [8+ROW_BITS-1:0] rom_addr;
   logic [GLYPH_W-1:0]    rom_data;
   logic                  pixel;
   logic                  out_valid;
   logic                  flash_phase;

   modport master (
      output in_valid, in_cell_start, char_code, row, alt_charset, col80, rom_data,
      input  rom_addr, pixel, out_valid, flash_phase
   );

   modport slave (
      input  in_valid, in_cell_start, char_code, row, alt_charset, col80, rom_data,
      output rom_addr, pixel, out_valid, flash_phase
   );
endinterface

// File: rtl/text_glyph_pipe.sv
// Streaming text-mode character generator: attribute decode, glyph ROM addressing,
// latency-matched attribute pipeline and 40/80-column pixel serialiser.
module text_glyph_pipe #(
   parameter int unsigned GLYPH_W      = 7,
   parameter int unsigned ROW_BITS     = 3,
   parameter int unsigned ROM_LATENCY  = 1,
   parameter int unsigned FLASH_PERIOD = 8119270,
   parameter int unsigned FLASH_W      = 24
) (
   input  logic               clkVGA,
   input  logic               rst,
   text_glyph_pipe_if.slave   bus
);

   localparam int unsigned ADDR_W = 8 + ROW_BITS;
   localparam int unsigned DEPTH  = ROM_LATENCY + 1;

   typedef struct packed {
      logic valid;
      logic cell_start;
      logic inv_eff;
      logic col80;
   } beat_t;

   logic [7:0]          idx_c;
   logic                inv_c;
   logic                flash_c;
   logic                cs_c;

   logic [ADDR_W-1:0]   rom_addr_d, rom_addr_q;
   beat_t               pipe_d [DEPTH];
   beat_t               pipe_q [DEPTH];
   beat_t               ob;

   logic [FLASH_W-1:0]  flash_cnt_d, flash_cnt_q;
   logic                flash_phase_d, flash_phase_q;

   logic [GLYPH_W-1:0]  sh_d, sh_q;
   logic                cur_bit_d, cur_bit_q;
   logic                half_d, half_q;
   logic                inv_d, inv_q;
   logic                mode80_d, mode80_q;
   logic                pixel_d, pixel_q;
   logic                out_valid_d, out_valid_q;

   // Character code to glyph index and attribute flags
   always_comb begin
      idx_c   = '0;
      inv_c   = 1'b0;
      flash_c = 1'b0;
      if (bus.char_code < 8'h40) begin
         inv_c = 1'b1;
         idx_c = bus.char_code ^ 8'h20;
      end else if (bus.char_code < 8'h80) begin
         if (bus.alt_charset) begin
            inv_c = 1'b1;
            idx_c = 8'h60 + (bus.char_code - 8'h40);
         end else begin
            flash_c = 1'b1;
            idx_c   = (bus.char_code - 8'h40) ^ 8'h20;
         end
      end else if (bus.char_code < 8'hA0) begin
         idx_c = bus.char_code - 8'h60;
      end else begin
         idx_c = bus.char_code - 8'hA0;
      end
   end

   // Stage 1 address capture and attribute delay line matched to ROM latency
   always_comb begin
      cs_c       = bus.in_valid & bus.in_cell_start;
      rom_addr_d = cs_c ? {idx_c, bus.row} : rom_addr_q;
      pipe_d[0].valid      = bus.in_valid;
      pipe_d[0].cell_start = cs_c;
      pipe_d[0].inv_eff    = inv_c | (flash_c & flash_phase_q);
      pipe_d[0].col80      = bus.col80;
      for (int i = 1; i < int'(DEPTH); i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // Free-running flash phase generator
   always_comb begin
      flash_cnt_d   = flash_cnt_q - FLASH_W'(1);
      flash_phase_d = flash_phase_q;
      if (flash_cnt_q == '0) begin
         flash_cnt_d   = FLASH_W'(FLASH_PERIOD - 1);
         flash_phase_d = ~flash_phase_q;
      end
   end

   assign ob = pipe_q[DEPTH-1];

   // Serialiser: half_q marks that the current bit still owes its second 40-col beat
   always_comb begin
      sh_d        = sh_q;
      cur_bit_d   = cur_bit_q;
      half_d      = half_q;
      inv_d       = inv_q;
      mode80_d    = mode80_q;
      pixel_d     = 1'b0;
      out_valid_d = ob.valid;
      if (ob.valid) begin
         if (ob.cell_start) begin
            cur_bit_d = bus.rom_data[GLYPH_W-1];
            sh_d      = bus.rom_data << 1;
            half_d    = 1'b1;
            inv_d     = ob.inv_eff;
            mode80_d  = ob.col80;
         end else if (mode80_q || !half_q) begin
            cur_bit_d = sh_q[GLYPH_W-1];
            sh_d      = sh_q << 1;
            half_d    = 1'b1;
         end else begin
            half_d    = 1'b0;
         end
         pixel_d = cur_bit_d ^ inv_d;
      end
   end

   always_ff @(posedge clkVGA) begin
      if (rst) begin
         rom_addr_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            pipe_q[i] <= '0;
         end
         flash_cnt_q   <= FLASH_W'(FLASH_PERIOD - 1);
         flash_phase_q <= 1'b0;
         sh_q          <= '0;
         cur_bit_q     <= 1'b0;
         half_q        <= 1'b0;
         inv_q         <= 1'b0;
         mode80_q      <= 1'b0;
         pixel_q       <= 1'b0;
         out_valid_q   <= 1'b0;
      end else begin
         rom_addr_q    <= rom_addr_d;
         pipe_q        <= pipe_d;
         flash_cnt_q   <= flash_cnt_d;
         flash_phase_q <= flash_phase_d;
         sh_q          <= sh_d;
         cur_bit_q     <= cur_bit_d;
         half_q        <= half_d;
         inv_q         <= inv_d;
         mode80_q      <= mode80_d;
         pixel_q       <= pixel_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign bus.rom_addr    = rom_addr_q;
   assign bus.pixel       = pixel_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.flash_phase = flash_phase_q;

endmodule

// File: tb/tb_text_glyph_pipe.sv
// Bench for text_glyph_pipe: ROM_LATENCY=1 and ROM_LATENCY=3 builds driven in lockstep
// and compared every cycle against a cell/position-level reference model.
module tb_text_glyph_pipe;

   localparam int unsigned FP    = 4;
   localparam int          LAT_A = 3;
   localparam int          LAT_B = 5;
   localparam int          NMAX  = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   text_glyph_pipe_if #(.GLYPH_W(7), .ROW_BITS(3)) bus_a ();
   text_glyph_pipe_if #(.GLYPH_W(7), .ROW_BITS(3)) bus_b ();

   text_glyph_pipe #(.GLYPH_W(7), .ROW_BITS(3), .ROM_LATENCY(1), .FLASH_PERIOD(FP), .FLASH_W(24))
      dut_a (.clkVGA(clk), .rst(rst), .bus(bus_a));
   text_glyph_pipe #(.GLYPH_W(7), .ROW_BITS(3), .ROM_LATENCY(3), .FLASH_PERIOD(FP), .FLASH_W(24))
      dut_b (.clkVGA(clk), .rst(rst), .bus(bus_b));

   function automatic logic [6:0] glyph(input logic [10:0] a);
      logic [31:0] h;
      if (a == 11'h10A || a == 11'h30A) return 7'b0011100;
      h = 32'(a) * 32'd2654435761;
      return h[22:16];
   endfunction

   // Glyph ROMs with one and three clocks of read latency
   logic [6:0] rb1 = '0, rb2 = '0;
   initial begin
      bus_a.rom_data = '0;
      bus_b.rom_data = '0;
   end
   always @(posedge clk) begin
      bus_a.rom_data <= glyph(bus_a.rom_addr);
      rb1            <= glyph(bus_b.rom_addr);
      rb2            <= rb1;
      bus_b.rom_data <= rb2;
   end

   int n_assert = 0;
   int n_fail   = 0;
   int edge_n   = 0;

   bit exp_val [2][NMAX];
   bit exp_pix [2][NMAX];
   bit obs_val [2][NMAX];
   bit obs_pix [2][NMAX];

   int          ksince    = 0;
   logic        has_cell  = 1'b0;
   logic [6:0]  cell_glyph = '0;
   logic        cell_inv  = 1'b0;
   logic        cell_c80  = 1'b0;
   int          cell_n    = 0;
   logic [10:0] last_addr = '0;
   logic        exp_phase = 1'b0;

   // Returns {inverse, flash, glyph index}
   function automatic logic [9:0] decode(input logic [7:0] c, input logic alt);
      if (c < 8'h40)      return {2'b10, 8'(c ^ 8'h20)};
      else if (c < 8'h80) return alt ? {2'b10, 8'(8'h60 + (c - 8'h40))} : {2'b01, 8'((c - 8'h40) ^ 8'h20)};
      else if (c < 8'hA0) return {2'b00, 8'(c - 8'h60)};
      else                return {2'b00, 8'(c - 8'hA0)};
   endfunction

   function automatic logic [15:0] seq(input bit sel_val, input int d, input int st, input int n);
      logic [15:0] r = '0;
      for (int i = 0; i < n; i++) r = {r[14:0], sel_val ? obs_val[d][st+i] : obs_pix[d][st+i]};
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic cs, input logic [7:0] code,
                       input logic [2:0] rw, input logic alt, input logic c80);
      logic [9:0]  dec;
      logic [10:0] addr;
      logic        ph;
      logic        pbit;
      int          pos;
      int          e;
      rst = r;
      bus_a.in_valid = v;  bus_a.in_cell_start = cs; bus_a.char_code = code;
      bus_a.row = rw;      bus_a.alt_charset = alt;   bus_a.col80 = c80;
      bus_b.in_valid = v;  bus_b.in_cell_start = cs; bus_b.char_code = code;
      bus_b.row = rw;      bus_b.alt_charset = alt;   bus_b.col80 = c80;
      @(posedge clk);
      e = edge_n;
      if (r) begin
         ksince = 0; has_cell = 1'b0; last_addr = '0; cell_n = 0;
         for (int i = 0; i < 10; i++) begin
            for (int d = 0; d < 2; d++) begin
               exp_val[d][e+i] = 1'b0;
               exp_pix[d][e+i] = 1'b0;
            end
         end
      end else begin
         ph = ((ksince / int'(FP)) % 2) == 1;
         ksince++;
         if (v) begin
            if (cs) begin
               dec        = decode(code, alt);
               addr       = {dec[7:0], rw};
               last_addr  = addr;
               has_cell   = 1'b1;
               cell_glyph = glyph(addr);
               cell_inv   = dec[9] | (dec[8] & ph);
               cell_c80   = c80;
               cell_n     = 0;
            end else begin
               cell_n++;
            end
            pos  = cell_c80 ? cell_n : cell_n / 2;
            pbit = (has_cell && pos < 7) ? cell_glyph[6-pos] : 1'b0;
            exp_val[0][e+LAT_A-1] = 1'b1;
            exp_pix[0][e+LAT_A-1] = pbit ^ (has_cell & cell_inv);
            exp_val[1][e+LAT_B-1] = 1'b1;
            exp_pix[1][e+LAT_B-1] = pbit ^ (has_cell & cell_inv);
         end
      end
      exp_phase = ((ksince / int'(FP)) % 2) == 1;
      #1;
      obs_val[0][e] = bus_a.out_valid; obs_pix[0][e] = bus_a.pixel;
      obs_val[1][e] = bus_b.out_valid; obs_pix[1][e] = bus_b.pixel;
      chk("a_out_valid", 32'(bus_a.out_valid),   32'(exp_val[0][e]));
      chk("a_pixel",     32'(bus_a.pixel),       32'(exp_pix[0][e]));
      chk("a_rom_addr",  32'(bus_a.rom_addr),    32'(last_addr));
      chk("a_flash",     32'(bus_a.flash_phase), 32'(exp_phase));
      chk("b_out_valid", 32'(bus_b.out_valid),   32'(exp_val[1][e]));
      chk("b_pixel",     32'(bus_b.pixel),       32'(exp_pix[1][e]));
      chk("b_rom_addr",  32'(bus_b.rom_addr),    32'(last_addr));
      chk("b_flash",     32'(bus_b.flash_phase), 32'(exp_phase));
      edge_n++;
   endtask

   task automatic beat(input logic cs, input logic [7:0] code, input logic [2:0] rw,
                       input logic alt, input logic c80);
      step(1'b0, 1'b1, cs, code, rw, alt, c80);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
   endtask

   initial begin
      int e0;
      logic c80r;
      bus_a.in_valid = 1'b0; bus_a.in_cell_start = 1'b0; bus_a.char_code = '0;
      bus_a.row = '0; bus_a.alt_charset = 1'b0; bus_a.col80 = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.in_cell_start = 1'b0; bus_b.char_code = '0;
      bus_b.row = '0; bus_b.alt_charset = 1'b0; bus_b.col80 = 1'b0;

      // Reset state
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      chk("rst_pixel", 32'(bus_a.pixel), 32'd0);
      chk("rst_valid", 32'(bus_a.out_valid), 32'd0);
      chk("rst_addr",  32'(bus_a.rom_addr), 32'd0);
      chk("rst_flash", 32'(bus_a.flash_phase), 32'd0);

      // Normal cell, 80 columns
      e0 = edge_n;
      beat(1'b1, 8'hC1, 3'd2, 1'b0, 1'b1);
      chk("addr_c1", 32'(bus_a.rom_addr), 32'h10A);
      for (int i = 0; i < 6; i++) beat(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      idle(6);
      chk("c1_seq_a", 32'(seq(1'b0, 0, e0+LAT_A-1, 7)), 32'b0011100);
      chk("c1_seq_b", 32'(seq(1'b0, 1, e0+LAT_B-1, 7)), 32'b0011100);

      // Inverse cell, 40 columns, beyond the glyph
      e0 = edge_n;
      beat(1'b1, 8'h01, 3'd2, 1'b0, 1'b0);
      chk("addr_inv", 32'(bus_a.rom_addr), 32'h10A);
      for (int i = 0; i < 15; i++) beat(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      idle(6);
      chk("inv40_seq", 32'(seq(1'b0, 0, e0+LAT_A-1, 16)), 32'b1111000000111111);

      // Flash bank versus alternate bank, started in both flash phases
      for (int k = 0; k < 4; k++) begin
         beat(1'b1, 8'h41, 3'd2, 1'b0, 1'b1);
         chk("addr_flash", 32'(bus_a.rom_addr), 32'h10A);
         for (int i = 0; i < 7; i++) beat(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
         beat(1'b1, 8'h41, 3'd2, 1'b1, 1'b1);
         chk("addr_alt", 32'(bus_a.rom_addr), 32'h30A);
         for (int i = 0; i < 7 + k; i++) beat(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      end
      idle(6);

      // Bubbles mid-cell
      e0 = edge_n;
      beat(1'b1, 8'hC1, 3'd2, 1'b0, 1'b1);
      beat(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      idle(3);
      for (int i = 0; i < 5; i++) beat(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      idle(6);
      chk("bub_val", 32'(seq(1'b1, 0, e0+LAT_A-1, 10)), 32'b1100011111);
      chk("bub_pix", 32'(seq(1'b0, 0, e0+LAT_A-1, 10)), 32'b0000011100);

      // Truncation by an early cell start
      e0 = edge_n;
      beat(1'b1, 8'hC1, 3'd2, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) beat(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      beat(1'b1, 8'h01, 3'd2, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) beat(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      idle(6);
      chk("trunc_a", 32'(seq(1'b0, 0, e0+LAT_A-1, 7)), 32'b0011110);
      chk("trunc_b", 32'(seq(1'b0, 1, e0+LAT_B-1, 7)), 32'b0011110);

      // Reset with beats in flight
      beat(1'b1, 8'h01, 3'd2, 1'b0, 1'b1);
      beat(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
      chk("mrst_pixel", 32'(bus_a.pixel), 32'd0);
      chk("mrst_valid", 32'(bus_a.out_valid), 32'd0);
      chk("mrst_flash", 32'(bus_a.flash_phase), 32'd0);
      idle(2);
      e0 = edge_n;
      beat(1'b1, 8'hC1, 3'd2, 1'b0, 1'b1);
      idle(7);
      chk("post_rst_a", 32'(seq(1'b1, 0, e0+LAT_A-2, 2)), 32'b01);
      chk("post_rst_b", 32'(seq(1'b1, 1, e0+LAT_B-2, 2)), 32'b01);

      // Randomised traffic
      c80r = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 29) == 0) c80r = ~c80r;
         step(($urandom_range(0, 249) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 9) == 0),
              8'($urandom),
              3'($urandom),
              1'($urandom),
              c80r);
      end
      idle(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
